// File: rtl/mygo_chan_reader.sv
// mygo_chan_reader
//   Receive-side endpoint of a mygo channel. Drains a channel FIFO read port
//   into a one-entry prefetch buffer and serves blocking receives
//   (`v, ok := <-ch`) to a process FSM over a req/done handshake.
//
// Ports
//   clk, rst        clock, asynchronous active-low reset
//   chan_rdata      FIFO read data
//   chan_rvalid     FIFO read data valid
//   chan_rready     accept chan_rdata this cycle (combinational: rst & ~buf_v)
//   chan_closed     writer has closed the channel (sticky level)
//   recv_req        process requests one receive, held until recv_done
//   recv_data       received value (0 when recv_ok = 0)
//   recv_ok         1 = real element, 0 = closed and drained
//   recv_done       one-cycle pulse, recv_data/recv_ok valid
//   recv_count      number of ok=1 deliveries, wraps modulo 2**CNT_W
//   busy            request pending (WAIT or DONE)
//
// Configuration
//   MYGO_CHAN_TRACE_EN  when defined, prints one trace line per recv_done cycle.
module mygo_chan_reader #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] chan_rdata,
  input  logic             chan_rvalid,
  output logic             chan_rready,
  input  logic             chan_closed,
  input  logic             recv_req,
  output logic [WIDTH-1:0] recv_data,
  output logic             recv_ok,
  output logic             recv_done,
  output logic [CNT_W-1:0] recv_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             take_ok_c;

  logic             buf_v_q, buf_v_d;
  logic [WIDTH-1:0] buf_d_q, buf_d_d;
  logic [WIDTH-1:0] recv_data_q, recv_data_d;
  logic             recv_ok_q, recv_ok_d;
  logic             recv_done_q, recv_done_d;
  logic [CNT_W-1:0] recv_count_q, recv_count_d;
  logic             busy_q, busy_d;
  logic             accept_c;

  // Prefetch buffer is refillable whenever it is empty and we are out of reset.
  assign chan_rready = rst & ~buf_v_q;
  assign accept_c    = chan_rvalid & chan_rready;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic. A word arriving in the same cycle as close is still
  // pending, so the ok=0 answer waits until the read port is quiet.
  always_comb begin
    state_d   = state_q;
    take_ok_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (recv_req) begin
          if (buf_v_q) begin
            state_d   = S_DONE;
            take_ok_c = 1'b1;
          end else if (chan_closed && !chan_rvalid) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (buf_v_q) begin
          state_d   = S_DONE;
          take_ok_c = 1'b1;
        end else if (chan_closed && !chan_rvalid) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic: buffer fill and drain, delivery registers.
  always_comb begin
    buf_v_d      = buf_v_q;
    buf_d_d      = buf_d_q;
    recv_data_d  = recv_data_q;
    recv_ok_d    = recv_ok_q;
    recv_count_d = recv_count_q;
    recv_done_d  = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
    if (accept_c) begin
      buf_v_d = 1'b1;
      buf_d_d = chan_rdata;
    end
    if (take_ok_c) begin
      // Buffer is full here, so accept_c is low and no refill collides.
      buf_v_d      = 1'b0;
      recv_data_d  = buf_d_q;
      recv_ok_d    = 1'b1;
      recv_count_d = recv_count_q + CNT_W'(1);
    end else if (state_d == S_DONE) begin
      recv_data_d = '0;
      recv_ok_d   = 1'b0;
    end
  end

  // Buffer and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_v_q      <= 1'b0;
      buf_d_q      <= '0;
      recv_data_q  <= '0;
      recv_ok_q    <= 1'b0;
      recv_done_q  <= 1'b0;
      recv_count_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      buf_v_q      <= buf_v_d;
      buf_d_q      <= buf_d_d;
      recv_data_q  <= recv_data_d;
      recv_ok_q    <= recv_ok_d;
      recv_done_q  <= recv_done_d;
      recv_count_q <= recv_count_d;
      busy_q       <= busy_d;
    end
  end

  assign recv_data  = recv_data_q;
  assign recv_ok    = recv_ok_q;
  assign recv_done  = recv_done_q;
  assign recv_count = recv_count_q;
  assign busy       = busy_q;

`ifdef MYGO_CHAN_TRACE_EN
  // Reads the registered values before this edge updates them.
  always @(posedge clk) begin
    if (rst && recv_done_q)
      $display("recv: count %d got 0x%x ok %d",
               recv_count_q, recv_data_q, recv_ok_q);
  end
`else
  // Trace disabled: no simulation output.
`endif

endmodule
